// File: rtl/mips_cpu_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_hilo_ctrl
// Description : Sequencer for the HI/LO multiply/divide unit. Accepts HI/LO
//               ops from execute, latches operands, models the iterative
//               latency with a down-counter and issues a one-cycle commit
//               strobe. Generates pipeline stalls, honours flush and flags
//               divide-by-zero without touching HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_hilo_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_valid_i,
    input  logic [2:0]  issue_op_i,
    input  logic [31:0] issue_a_i,
    input  logic [31:0] issue_b_i,
    output logic        issue_ready_o,
    input  logic        flush_i,
    input  logic        read_req_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [2:0]  unit_op_o,
    output logic [31:0] unit_a_o,
    output logic [31:0] unit_b_o,
    output logic        unit_write_o,
    output logic        done_o,
    output logic        div_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Counter preload values: the counter reaches zero on the last BUSY cycle.
    localparam logic [5:0] c_MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] c_DIV_LOAD  = 6'(DIV_CYCLES - 1);

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        div_zero_q;

    logic        w_idle;
    logic        w_accept;
    logic        w_is_arith;
    logic        w_is_mult;
    logic        w_is_mt;
    logic        w_b_zero;

    assign w_idle     = (state_q == S_IDLE);
    assign w_accept   = issue_valid_i && w_idle;
    // op[2]==0: DIVU/MULTU/DIV/MULT; op[0] selects multiply within that group.
    assign w_is_arith = !issue_op_i[2];
    assign w_is_mult  = w_is_arith && issue_op_i[0];
    // op 100/101 are MTHI/MTLO; 110/111 are reads and never occupy the unit.
    assign w_is_mt    = issue_op_i[2] && !issue_op_i[1];
    assign w_b_zero   = (issue_b_i == 32'd0);

    // Controller state, latency counter, operand latches and div-zero flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            op_q       <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Flush is ignored here: a squashed op arrives with valid low.
                    if (w_accept) begin
                        op_q <= issue_op_i;
                        a_q  <= issue_a_i;
                        b_q  <= issue_b_i;
                        if (w_is_mult) begin
                            state_q <= S_BUSY;
                            cnt_q   <= c_MULT_LOAD;
                        end else if (w_is_arith) begin
                            if (w_b_zero) begin
                                div_zero_q <= 1'b1;
                            end else begin
                                state_q <= S_BUSY;
                                cnt_q   <= c_DIV_LOAD;
                            end
                        end else if (w_is_mt) begin
                            state_q <= S_COMMIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 6'd0;
                    end else if (cnt_q == 6'd0) begin
                        state_q <= S_COMMIT;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 6'd0;
                end
            endcase
        end
    end

    // Outputs decoded from state; flush squashes the commit and div-zero pulses
    // in the very cycle it is seen.
    always_comb begin
        issue_ready_o = w_idle;
        busy_o        = !w_idle;
        stall_o       = (read_req_i && !w_idle) || (issue_valid_i && !w_idle);
        unit_write_o  = (state_q == S_COMMIT) && !flush_i;
        done_o        = (state_q == S_COMMIT) && !flush_i;
        div_zero_o    = div_zero_q && !flush_i;
        unit_op_o     = op_q;
        unit_a_o      = a_q;
        unit_b_o      = b_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_hilo_ctrl
// Description : Self-checking bench for mips_cpu_hilo_ctrl. A cycles-remaining
//               reference model predicts every output each cycle; directed
//               scenarios add literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_hilo_ctrl;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        issue_ready;
    logic        flush;
    logic        read_req;
    logic        stall;
    logic        busy;
    logic [2:0]  unit_op;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        unit_write;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: number of cycles still occupied (BUSY cycles + COMMIT).
    int          m_left;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_dz;

    mips_cpu_hilo_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .issue_valid_i(issue_valid),
        .issue_op_i   (issue_op),
        .issue_a_i    (issue_a),
        .issue_b_i    (issue_b),
        .issue_ready_o(issue_ready),
        .flush_i      (flush),
        .read_req_i   (read_req),
        .stall_o      (stall),
        .busy_o       (busy),
        .unit_op_o    (unit_op),
        .unit_a_o     (unit_a),
        .unit_b_o     (unit_b),
        .unit_write_o (unit_write),
        .done_o       (done),
        .div_zero_o   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_op   = 3'd0;
        m_a    = 32'd0;
        m_b    = 32'd0;
        m_dz   = 1'b0;
    endtask

    // Compare every DUT output with what the model predicts for this cycle.
    task automatic model_compare();
        logic occ;
        occ = (m_left > 0);
        check("issue_ready", {31'd0, issue_ready}, {31'd0, !occ});
        check("busy",        {31'd0, busy},        {31'd0, occ});
        check("stall",       {31'd0, stall},       {31'd0, (read_req && occ) || (issue_valid && occ)});
        check("unit_write",  {31'd0, unit_write},  {31'd0, (m_left == 1) && !flush});
        check("done",        {31'd0, done},        {31'd0, (m_left == 1) && !flush});
        check("div_zero",    {31'd0, div_zero},    {31'd0, m_dz && !flush});
        check("unit_op",     {29'd0, unit_op},     {29'd0, m_op});
        check("unit_a",      unit_a,               m_a);
        check("unit_b",      unit_b,               m_b);
    endtask

    // Advance the model across one rising edge using the applied inputs.
    task automatic model_update();
        m_dz = 1'b0;
        if (m_left > 0) begin
            if (flush) m_left = 0;
            else       m_left = m_left - 1;
        end else if (issue_valid) begin
            m_op = issue_op;
            m_a  = issue_a;
            m_b  = issue_b;
            if (issue_op < 3'd4) begin
                if (issue_op[0])          m_left = MULT_CYCLES + 1;
                else if (issue_b != 32'd0) m_left = DIV_CYCLES + 1;
                else                      m_dz = 1'b1;
            end else if (issue_op < 3'd6) begin
                m_left = 1;
            end
        end
    endtask

    // Apply inputs shortly after the falling edge and check against the model.
    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic rd);
        issue_valid = v;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        flush       = fl;
        read_req    = rd;
        #1;
        model_compare();
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int at;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = 3'd0;
        issue_a     = 32'd0;
        issue_b     = 32'd0;
        flush       = 1'b0;
        read_req    = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        idle();
        check("rst issue_ready", {31'd0, issue_ready}, 32'd1);
        check("rst busy",        {31'd0, busy},        32'd0);
        check("rst unit_write",  {31'd0, unit_write},  32'd0);
        check("rst unit_a",      unit_a,               32'd0);
        rst_n = 1'b1;
        adv();

        // MULT 3 * 0xFFFFFFFE: busy N+1..N+5, commit in N+5
        drive(1'b1, 3'b011, 32'h3, 32'hFFFF_FFFE, 1'b0, 1'b0);
        check("mult accept ready", {31'd0, issue_ready}, 32'd1);
        adv();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'b001, 32'h55, 32'h66, 1'b0, 1'b0);
            check("mult busy",  {31'd0, busy},       32'd1);
            check("mult ready", {31'd0, issue_ready}, 32'd0);
            check("mult nowr",  {31'd0, unit_write}, 32'd0);
            adv();
        end
        idle();
        check("mult write", {31'd0, unit_write}, 32'd1);
        check("mult done",  {31'd0, done},       32'd1);
        check("mult op",    {29'd0, unit_op},    32'd3);
        check("mult a",     unit_a,              32'd3);
        check("mult b",     unit_b,              32'hFFFF_FFFE);
        adv();
        idle();
        check("mult after busy", {31'd0, busy}, 32'd0);
        adv();

        // DIVU 100/7 with read_req held: 33 stall cycles, write in the 33rd
        drive(1'b1, 3'b000, 32'd100, 32'd7, 1'b0, 1'b0);
        adv();
        cnt = 0;
        at  = 0;
        for (int i = 1; i <= 40; i++) begin
            drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
            if (stall) cnt++;
            if (unit_write) at = i;
            adv();
        end
        check("divu stall cycles", cnt, 32'd33);
        check("divu write cycle",  at,  32'd33);

        // DIV 5/0: div_zero pulse, no write, stays idle
        drive(1'b1, 3'b010, 32'd5, 32'd0, 1'b0, 1'b0);
        adv();
        idle();
        check("dz pulse", {31'd0, div_zero},    32'd1);
        check("dz nowr",  {31'd0, unit_write},  32'd0);
        check("dz busy",  {31'd0, busy},        32'd0);
        check("dz ready", {31'd0, issue_ready}, 32'd1);
        adv();
        idle();
        check("dz one cycle", {31'd0, div_zero}, 32'd0);
        adv();

        // MTLO then MFLO
        drive(1'b1, 3'b101, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        adv();
        idle();
        check("mtlo write", {31'd0, unit_write}, 32'd1);
        check("mtlo op",    {29'd0, unit_op},    32'd5);
        check("mtlo a",     unit_a,              32'hDEAD_BEEF);
        adv();
        drive(1'b1, 3'b111, 32'd0, 32'd0, 1'b0, 1'b1);
        check("mflo stall", {31'd0, stall},       32'd0);
        check("mflo ready", {31'd0, issue_ready}, 32'd1);
        adv();
        idle();
        check("mflo nowr", {31'd0, unit_write}, 32'd0);
        check("mflo busy", {31'd0, busy},       32'd0);
        adv();

        // MULT flushed in its 2nd BUSY cycle, then MULTU runs normally
        drive(1'b1, 3'b011, 32'd9, 32'd9, 1'b0, 1'b0);
        adv();
        idle();
        adv();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("flush nowr", {31'd0, unit_write}, 32'd0);
        adv();
        idle();
        check("flush idle", {31'd0, busy}, 32'd0);
        adv();
        drive(1'b1, 3'b001, 32'd7, 32'd9, 1'b0, 1'b0);
        adv();
        for (int i = 1; i <= 4; i++) begin
            idle();
            check("multu busy", {31'd0, busy},       32'd1);
            check("multu nowr", {31'd0, unit_write}, 32'd0);
            adv();
        end
        idle();
        check("multu write", {31'd0, unit_write}, 32'd1);
        check("multu op",    {29'd0, unit_op},    32'd1);
        adv();

        // Asynchronous reset during DIV BUSY
        drive(1'b1, 3'b010, 32'd50, 32'd3, 1'b0, 1'b0);
        adv();
        for (int i = 0; i < 5; i++) begin
            idle();
            adv();
        end
        idle();
        rst_n = 1'b0;
        #1;
        check("areset busy",  {31'd0, busy},        32'd0);
        check("areset ready", {31'd0, issue_ready}, 32'd1);
        check("areset op",    {29'd0, unit_op},     32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        adv();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (unit_write) cnt++;
            adv();
        end
        check("areset no write", cnt, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1,
                  3'($urandom),
                  $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) == 0);
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
